stack_sequencer: RTL and testbench

- Multi-cycle controller for all stack-based control transfers: CALL, RET, hardware interrupt (INT) and RTI.
- Sits beside the execute stage and drives the stack-pointer, memory-access and PC-load controls as a sequence of 16-bit stack transactions.
- Stalls the front end while it runs, because a 32-bit PC plus 3-bit flags does not fit in one 16-bit memory slot.
- Owns its stack ordering: push flags, PC[31:16], PC[15:0]; pop in reverse order.

---
 rtl/stack_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_stack_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_sequencer.sv
// ---------------------------------------------------------------------------
// stack_sequencer
//   Multi-cycle controller for CALL, RET, hardware interrupt entry (INT) and
//   RTI. Each transfer is broken into 16-bit stack transactions while the
//   front end is stalled. Stack order on push: flags, PC[31:16], PC[15:0];
//   pops run in reverse.
//
//   Optional build macro: INT_MASK_EN
//     When defined, an internal interrupt-enable bit masks pending INTs. The
//     bit is cleared on INT entry and set again by the LOAD step of RTI.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   int_req                  one-cycle interrupt pulse (held pending internally)
//   call_req/ret_req/rti_req decoded transfer requests, held while stall=1
//   pc_in, call_target       return PC and CALL destination, latched on accept
//   flags_in                 current {NF,CF,ZF}, latched on accept
//   mem_rdata                stack read data, valid the cycle after mem_rd
//   stall                    freeze fetch/decode
//   mem_wr/sp_dec, wdata     push strobe, SP decrement, push data
//   mem_rd/sp_inc            pop strobe, SP increment
//   pc_load, pc_out          PC load strobe and new PC
//   flags_load, flags_out    flag register load strobe and restored flags
//   int_ack                  one-cycle acknowledge on interrupt entry
//   busy                     sequencer is not idle
// ---------------------------------------------------------------------------
module stack_sequencer #(
  parameter logic [31:0] INT_VECTOR = 32'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_req,
  input  logic        call_req,
  input  logic        ret_req,
  input  logic        rti_req,
  input  logic [31:0] pc_in,
  input  logic [31:0] call_target,
  input  logic [2:0]  flags_in,
  input  logic [15:0] mem_rdata,
  output logic        stall,
  output logic        mem_wr,
  output logic        mem_rd,
  output logic        sp_dec,
  output logic        sp_inc,
  output logic [15:0] wdata,
  output logic        pc_load,
  output logic [31:0] pc_out,
  output logic        flags_load,
  output logic [2:0]  flags_out,
  output logic        int_ack,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_PUSH_FL, S_PUSH_PCH, S_PUSH_PCL,
    S_POP_PCL, S_POP_PCH, S_POP_FL, S_CAP, S_LOAD
  } state_t;

  typedef enum logic [1:0] {OP_CALL, OP_INT, OP_RET, OP_RTI} op_t;

  state_t      r_state, w_next;
  op_t         r_op, w_op;
  logic        r_int_pending;
  logic [31:0] r_pc, r_target;
  logic [2:0]  r_flags, r_rflags;
  logic [15:0] r_lo, r_hi;
  logic        w_int_ok, w_accept;

`ifdef INT_MASK_EN
  logic r_int_en;
  assign w_int_ok = (r_int_pending | int_req) & r_int_en;
`else
  assign w_int_ok = r_int_pending | int_req;
`endif

  // Request arbitration: only in IDLE, INT > RTI > RET > CALL. A raw int_req
  // counts so an INT arriving alongside a CALL wins in the same cycle.
  always_comb begin
    w_op     = OP_CALL;
    w_accept = 1'b0;
    if (!rst && r_state == S_IDLE) begin
      w_accept = w_int_ok | rti_req | ret_req | call_req;
      if (w_int_ok)     w_op = OP_INT;
      else if (rti_req) w_op = OP_RTI;
      else if (ret_req) w_op = OP_RET;
      else              w_op = OP_CALL;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (w_op)
            OP_INT:  w_next = S_PUSH_FL;
            OP_CALL: w_next = S_PUSH_PCH;
            default: w_next = S_POP_PCL;
          endcase
        end
      end
      S_PUSH_FL:  w_next = S_PUSH_PCH;
      S_PUSH_PCH: w_next = S_PUSH_PCL;
      S_PUSH_PCL: w_next = S_LOAD;
      S_POP_PCL:  w_next = S_POP_PCH;
      S_POP_PCH:  w_next = (r_op == OP_RTI) ? S_POP_FL : S_CAP;
      S_POP_FL:   w_next = S_CAP;
      S_CAP:      w_next = S_LOAD;
      S_LOAD:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_op          <= OP_CALL;
      r_int_pending <= 1'b0;
      r_pc          <= '0;
      r_target      <= '0;
      r_flags       <= '0;
      r_rflags      <= '0;
      r_lo          <= '0;
      r_hi          <= '0;
    end else begin
      r_state <= w_next;
      // Accepting an INT clears the pending bit, but an int_req in that same
      // cycle re-arms it only if the accepted INT was the already-pending one
      // (otherwise the raw pulse itself is what got accepted).
      if (w_accept && w_op == OP_INT) r_int_pending <= int_req & r_int_pending;
      else if (int_req)               r_int_pending <= 1'b1;
      if (w_accept) begin
        r_op     <= w_op;
        r_pc     <= pc_in;
        r_target <= call_target;
        r_flags  <= flags_in;
      end
      // Read data lags mem_rd by one cycle, so each capture sits one state
      // after the pop that requested it.
      case (r_state)
        S_POP_PCH: r_lo <= mem_rdata;
        S_POP_FL:  r_hi <= mem_rdata;
        S_CAP: begin
          if (r_op == OP_RTI) r_rflags <= mem_rdata[2:0];
          else                r_hi     <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

`ifdef INT_MASK_EN
  always_ff @(posedge clk) begin
    if (rst)                                        r_int_en <= 1'b1;
    else if (w_accept && w_op == OP_INT)            r_int_en <= 1'b0;
    else if (r_state == S_LOAD && r_op == OP_RTI)   r_int_en <= 1'b1;
  end
`endif

  // Outputs are forced low while rst is high so an aborted sequence issues
  // no further strobes.
  always_comb begin
    stall      = 1'b0;
    mem_wr     = 1'b0;
    mem_rd     = 1'b0;
    sp_dec     = 1'b0;
    sp_inc     = 1'b0;
    wdata      = '0;
    pc_load    = 1'b0;
    pc_out     = '0;
    flags_load = 1'b0;
    flags_out  = '0;
    int_ack    = 1'b0;
    busy       = 1'b0;
    if (!rst) begin
      busy  = (r_state != S_IDLE);
      stall = busy | w_accept;
      case (r_state)
        S_PUSH_FL: begin
          mem_wr = 1'b1;
          sp_dec = 1'b1;
          wdata  = {13'b0, r_flags};
        end
        S_PUSH_PCH: begin
          mem_wr = 1'b1;
          sp_dec = 1'b1;
          wdata  = r_pc[31:16];
        end
        S_PUSH_PCL: begin
          mem_wr = 1'b1;
          sp_dec = 1'b1;
          wdata  = r_pc[15:0];
        end
        S_POP_PCL, S_POP_PCH, S_POP_FL: begin
          mem_rd = 1'b1;
          sp_inc = 1'b1;
        end
        S_LOAD: begin
          pc_load = 1'b1;
          case (r_op)
            OP_CALL: pc_out = r_target;
            OP_INT: begin
              pc_out  = INT_VECTOR;
              int_ack = 1'b1;
            end
            OP_RTI: begin
              pc_out     = {r_hi, r_lo};
              flags_load = 1'b1;
              flags_out  = r_rflags;
            end
            default: pc_out = {r_hi, r_lo};
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
module tb_stack_sequencer;

  logic        clk, rst, int_req, call_req, ret_req, rti_req;
  logic [31:0] pc_in, call_target;
  logic [2:0]  flags_in;
  logic [15:0] mem_rdata;
  logic        stall, mem_wr, mem_rd, sp_dec, sp_inc;
  logic [15:0] wdata;
  logic        pc_load;
  logic [31:0] pc_out;
  logic        flags_load;
  logic [2:0]  flags_out;
  logic        int_ack, busy;

  int n_pass = 0;
  int n_total = 0;

  stack_sequencer #(.INT_VECTOR(32'd2)) dut (
    .clk(clk), .rst(rst), .int_req(int_req), .call_req(call_req),
    .ret_req(ret_req), .rti_req(rti_req), .pc_in(pc_in),
    .call_target(call_target), .flags_in(flags_in), .mem_rdata(mem_rdata),
    .stall(stall), .mem_wr(mem_wr), .mem_rd(mem_rd), .sp_dec(sp_dec),
    .sp_inc(sp_inc), .wdata(wdata), .pc_load(pc_load), .pc_out(pc_out),
    .flags_load(flags_load), .flags_out(flags_out), .int_ack(int_ack),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    int_req = 0; call_req = 0; ret_req = 0; rti_req = 0;
    pc_in = '0; call_target = '0; flags_in = '0; mem_rdata = '0;
    next_cyc();
    next_cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    call_req = 1'b1; int_req = 1'b1;
    next_cyc();
    @(negedge clk);
    n_total++;
    if ({stall, mem_wr, mem_rd, sp_dec, sp_inc, wdata, pc_load, pc_out,
         flags_load, flags_out, int_ack, busy} !== 60'd0)
      $display("FAIL reset_outputs: stall=%b busy=%b wr=%b rd=%b pc_load=%b expected all 0",
               stall, busy, mem_wr, mem_rd, pc_load);
    else n_pass++;
    do_reset();
    @(negedge clk);
    n_total++;
    if ({stall, busy} !== 2'b00) $display("FAIL reset_idle: stall/busy=%b%b expected 00", stall, busy);
    else n_pass++;
    next_cyc();
  endtask

  task automatic test_call();
    int stalls = 0;
    do_reset();
    pc_in = 32'h0001_0024; call_target = 32'h0000_0100; call_req = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (stall) stalls++;
      n_total++;
      if ({mem_wr, sp_dec} !== {2{c == 1 || c == 2}})
        $display("FAIL call_push c%0d: wr/dec=%b%b expected %b", c, mem_wr, sp_dec, (c == 1 || c == 2));
      else n_pass++;
      n_total++;
      if ({mem_rd, sp_inc, flags_load, int_ack} !== 4'b0)
        $display("FAIL call_quiet c%0d: rd/inc/fl/ack=%b%b%b%b expected 0000", c, mem_rd, sp_inc, flags_load, int_ack);
      else n_pass++;
      n_total++;
      if (pc_load !== (c == 3)) $display("FAIL call_pc_load c%0d: got %b expected %b", c, pc_load, (c == 3));
      else n_pass++;
      if (c == 0) begin
        n_total++;
        if ({stall, busy} !== 2'b10) $display("FAIL call_accept: stall/busy=%b%b expected 10", stall, busy);
        else n_pass++;
      end
      if (c == 1 || c == 2) begin
        n_total++;
        if (wdata !== ((c == 1) ? 16'h0001 : 16'h0024))
          $display("FAIL call_wdata c%0d: got %h expected %h", c, wdata, (c == 1) ? 16'h0001 : 16'h0024);
        else n_pass++;
      end
      if (c == 3) begin
        n_total++;
        if (pc_out !== 32'h0000_0100) $display("FAIL call_pc_out: got %h expected 00000100", pc_out);
        else n_pass++;
      end
      next_cyc();
      if (c == 3) call_req = 1'b0;
    end
    n_total++;
    if (stalls != 4) $display("FAIL call_stall_len: got %0d expected 4", stalls);
    else n_pass++;
  endtask

  task automatic test_ret();
    int stalls = 0;
    do_reset();
    ret_req = 1'b1;
    for (int c = 0; c < 7; c++) begin
      mem_rdata = (c == 2) ? 16'h0024 : (c == 3) ? 16'h0001 : 16'hDEAD;
      @(negedge clk);
      if (stall) stalls++;
      n_total++;
      if ({mem_rd, sp_inc} !== {2{c == 1 || c == 2}})
        $display("FAIL ret_pop c%0d: rd/inc=%b%b expected %b", c, mem_rd, sp_inc, (c == 1 || c == 2));
      else n_pass++;
      n_total++;
      if ({mem_wr, sp_dec} !== 2'b00) $display("FAIL ret_nowr c%0d: wr/dec=%b%b expected 00", c, mem_wr, sp_dec);
      else n_pass++;
      n_total++;
      if (pc_load !== (c == 4)) $display("FAIL ret_pc_load c%0d: got %b expected %b", c, pc_load, (c == 4));
      else n_pass++;
      if (c == 4) begin
        n_total++;
        if (pc_out !== 32'h0001_0024) $display("FAIL ret_pc_out: got %h expected 00010024", pc_out);
        else n_pass++;
        n_total++;
        if (flags_load !== 1'b0) $display("FAIL ret_flags_load: got %b expected 0", flags_load);
        else n_pass++;
      end
      next_cyc();
      if (c == 4) ret_req = 1'b0;
    end
    n_total++;
    if (stalls != 5) $display("FAIL ret_stall_len: got %0d expected 5", stalls);
    else n_pass++;
  endtask

  task automatic test_int();
    int stalls = 0;
    int acks = 0;
    do_reset();
    pc_in = 32'h0000_0010; flags_in = 3'b101; int_req = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (stall) stalls++;
      if (int_ack) acks++;
      n_total++;
      if ({mem_wr, sp_dec} !== {2{c >= 1 && c <= 3}})
        $display("FAIL int_push c%0d: wr/dec=%b%b expected %b", c, mem_wr, sp_dec, (c >= 1 && c <= 3));
      else n_pass++;
      if (c >= 1 && c <= 3) begin
        n_total++;
        if (wdata !== ((c == 1) ? 16'h0005 : (c == 2) ? 16'h0000 : 16'h0010))
          $display("FAIL int_wdata c%0d: got %h", c, wdata);
        else n_pass++;
      end
      n_total++;
      if ({pc_load, int_ack} !== {2{c == 4}})
        $display("FAIL int_load c%0d: pc_load/ack=%b%b expected %b", c, pc_load, int_ack, (c == 4));
      else n_pass++;
      if (c == 4) begin
        n_total++;
        if (pc_out !== 32'd2) $display("FAIL int_vector: got %h expected 00000002", pc_out);
        else n_pass++;
      end
      next_cyc();
      int_req = 1'b0;
    end
    n_total++;
    if (stalls != 5) $display("FAIL int_stall_len: got %0d expected 5", stalls);
    else n_pass++;
    n_total++;
    if (acks != 1) $display("FAIL int_ack_count: got %0d expected 1", acks);
    else n_pass++;
  endtask

  task automatic test_rti();
    int stalls = 0;
    do_reset();
    rti_req = 1'b1;
    for (int c = 0; c < 8; c++) begin
      mem_rdata = (c == 2) ? 16'h0010 : (c == 3) ? 16'h0000 : (c == 4) ? 16'h0005 : 16'hBEEF;
      @(negedge clk);
      if (stall) stalls++;
      n_total++;
      if ({mem_rd, sp_inc} !== {2{c >= 1 && c <= 3}})
        $display("FAIL rti_pop c%0d: rd/inc=%b%b expected %b", c, mem_rd, sp_inc, (c >= 1 && c <= 3));
      else n_pass++;
      n_total++;
      if ({pc_load, flags_load} !== {2{c == 5}})
        $display("FAIL rti_load c%0d: pc_load/flags_load=%b%b expected %b", c, pc_load, flags_load, (c == 5));
      else n_pass++;
      if (c == 5) begin
        n_total++;
        if (pc_out !== 32'h0000_0010) $display("FAIL rti_pc_out: got %h expected 00000010", pc_out);
        else n_pass++;
        n_total++;
        if (flags_out !== 3'b101) $display("FAIL rti_flags_out: got %b expected 101", flags_out);
        else n_pass++;
      end
      next_cyc();
      if (c == 5) rti_req = 1'b0;
    end
    n_total++;
    if (stalls != 6) $display("FAIL rti_stall_len: got %0d expected 6", stalls);
    else n_pass++;
  endtask

  task automatic test_priority();
    do_reset();
    pc_in = 32'h0002_0040; call_target = 32'h0000_0300; flags_in = 3'b010;
    int_req = 1'b1; call_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_total++;
        if ({mem_wr, wdata} !== {1'b1, 16'h0002}) $display("FAIL prio_int_first: wr=%b wdata=%h expected 1/0002", mem_wr, wdata);
        else n_pass++;
      end
      if (c == 4) begin
        n_total++;
        if ({int_ack, pc_out} !== {1'b1, 32'd2}) $display("FAIL prio_int_load: ack=%b pc_out=%h expected 1/00000002", int_ack, pc_out);
        else n_pass++;
      end
      if (c == 5) begin
        n_total++;
        if ({stall, busy} !== 2'b10) $display("FAIL prio_call_accept: stall/busy=%b%b expected 10", stall, busy);
        else n_pass++;
      end
      if (c == 6 || c == 7) begin
        n_total++;
        if ({mem_wr, wdata} !== {1'b1, (c == 6) ? 16'h0002 : 16'h0040})
          $display("FAIL prio_call_push c%0d: wr=%b wdata=%h", c, mem_wr, wdata);
        else n_pass++;
      end
      if (c == 8) begin
        n_total++;
        if ({pc_load, int_ack, pc_out} !== {2'b10, 32'h0000_0300})
          $display("FAIL prio_call_load: pc_load=%b ack=%b pc_out=%h expected 1/0/00000300", pc_load, int_ack, pc_out);
        else n_pass++;
      end
      if (c == 9) begin
        n_total++;
        if (stall !== 1'b0) $display("FAIL prio_done: stall=%b expected 0", stall);
        else n_pass++;
      end
      next_cyc();
      int_req = 1'b0;
      if (c == 8) call_req = 1'b0;
    end
  endtask

  task automatic test_int_pending();
    do_reset();
    pc_in = 32'h0000_0040; call_target = 32'h0000_0200; flags_in = 3'b011;
    call_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      int_req = (c == 1);
      @(negedge clk);
      if (c == 2) begin
        n_total++;
        if ({mem_wr, wdata} !== {1'b1, 16'h0040}) $display("FAIL pend_call_push: wr=%b wdata=%h expected 1/0040", mem_wr, wdata);
        else n_pass++;
      end
      if (c == 3) begin
        n_total++;
        if ({pc_load, pc_out} !== {1'b1, 32'h0000_0200}) $display("FAIL pend_call_load: pc_load=%b pc_out=%h", pc_load, pc_out);
        else n_pass++;
      end
      if (c == 4) begin
        n_total++;
        if ({stall, busy} !== 2'b10) $display("FAIL pend_int_accept: stall/busy=%b%b expected 10", stall, busy);
        else n_pass++;
      end
      if (c == 5) begin
        n_total++;
        if ({mem_wr, wdata} !== {1'b1, 16'h0003}) $display("FAIL pend_int_flags: wr=%b wdata=%h expected 1/0003", mem_wr, wdata);
        else n_pass++;
      end
      if (c == 8) begin
        n_total++;
        if ({int_ack, pc_out} !== {1'b1, 32'd2}) $display("FAIL pend_int_load: ack=%b pc_out=%h", int_ack, pc_out);
        else n_pass++;
      end
      if (c == 9) begin
        n_total++;
        if (stall !== 1'b0) $display("FAIL pend_cleared: stall=%b expected 0", stall);
        else n_pass++;
      end
      next_cyc();
      if (c == 3) call_req = 1'b0;
    end
    int_req = 1'b0;
  endtask

  task automatic test_rst_abort();
    do_reset();
    pc_in = 32'h1234_5678; flags_in = 3'b111;
    for (int c = 0; c < 6; c++) begin
      int_req = (c == 0 || c == 1);
      rst = (c == 2);
      @(negedge clk);
      if (c == 2 || c == 3) begin
        n_total++;
        if ({stall, mem_wr, mem_rd, sp_dec, sp_inc, wdata, pc_load, pc_out,
             flags_load, flags_out, int_ack, busy} !== 60'd0)
          $display("FAIL rst_abort c%0d: stall=%b busy=%b wr=%b wdata=%h expected all 0", c, stall, busy, mem_wr, wdata);
        else n_pass++;
      end
      if (c >= 4) begin
        n_total++;
        if ({stall, busy} !== 2'b00) $display("FAIL rst_pend_cleared c%0d: stall/busy=%b%b expected 00", c, stall, busy);
        else n_pass++;
      end
      next_cyc();
    end
    int_req = 1'b0; rst = 1'b0;
  endtask

`ifdef INT_MASK_EN
  task automatic test_mask();
    do_reset();
    for (int c = 0; c < 15; c++) begin
      int_req = (c == 0 || c == 5);
      rti_req = (c >= 7 && c <= 12);
      @(negedge clk);
      if (c == 5 || c == 6) begin
        n_total++;
        if (stall !== 1'b0) $display("FAIL mask_defer c%0d: stall=%b expected 0", c, stall);
        else n_pass++;
      end
      if (c == 8) begin
        n_total++;
        if ({mem_rd, mem_wr} !== 2'b10) $display("FAIL mask_rti_first: rd/wr=%b%b expected 10", mem_rd, mem_wr);
        else n_pass++;
      end
      if (c == 13) begin
        n_total++;
        if ({stall, busy} !== 2'b10) $display("FAIL mask_int_after_rti: stall/busy=%b%b expected 10", stall, busy);
        else n_pass++;
      end
      if (c == 14) begin
        n_total++;
        if (mem_wr !== 1'b1) $display("FAIL mask_int_push: wr=%b expected 1", mem_wr);
        else n_pass++;
      end
      next_cyc();
    end
    int_req = 1'b0; rti_req = 1'b0;
  endtask
`endif

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    int_req = 0; call_req = 0; ret_req = 0; rti_req = 0;
    pc_in = '0; call_target = '0; flags_in = '0; mem_rdata = '0;
    #1;
    test_reset();
    test_call();
    test_ret();
    test_int();
    test_rti();
    test_priority();
    test_int_pending();
    test_rst_abort();
`ifdef INT_MASK_EN
    test_mask();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
